// File: rtl/tile_mem_arbiter.sv
// Round-robin request arbiter and word-interleaved bank router in front of the tile SRAM.
// Optional conflict counters are built in when TILE_ARB_PERF_EN is defined.
module tile_mem_arbiter #(
  parameter int REQS            = 4,
  parameter int BANKS           = 4,
  parameter int ADDR_WIDTH      = 15,
  parameter int BANK_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH      = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQS-1:0]                  req_valid,
  output logic [REQS-1:0]                  req_ready,
  input  logic [REQS-1:0]                  req_we,
  input  logic [REQS*ADDR_WIDTH-1:0]       req_addr,
  input  logic [REQS*DATA_WIDTH-1:0]       req_wdata,
  output logic [REQS-1:0]                  resp_valid,
  output logic [REQS*DATA_WIDTH-1:0]       resp_rdata,
  output logic [BANKS-1:0]                 bank_enable,
  output logic [BANKS-1:0]                 bank_write_en,
  output logic [BANKS*BANK_ADDR_WIDTH-1:0] bank_addr,
  output logic [BANKS*DATA_WIDTH-1:0]      bank_wdata,
  input  logic [BANKS*DATA_WIDTH-1:0]      bank_rdata,
  input  logic [BANKS-1:0]                 bank_ready
`ifdef TILE_ARB_PERF_EN
  ,
  output logic [BANKS*16-1:0]              perf_conflict_cnt
`endif
);

  localparam int BB     = $clog2(BANKS);
  localparam int IDW    = $clog2(REQS);
  localparam int WORD_W = ADDR_WIDTH - 3 - BB;

  // Handshake: a request transfers in any cycle where req_valid[r] & req_ready[r];
  // req_ready is computed from req_valid, never the other way round.

  logic [BB-1:0]              w_req_bank  [REQS];
  logic [BANK_ADDR_WIDTH-1:0] w_req_baddr [REQS];
  logic [REQS-1:0]            w_cand      [BANKS];
  logic [BANKS-1:0]           w_found;
  logic [BANKS-1:0]           w_gnt;
  logic [IDW-1:0]             w_win       [BANKS];
  logic [REQS-1:0]            w_ready;
  logic [REQS-1:0]            w_resp_vld;
  logic [REQS*3-1:0]          w_unused;

  logic [IDW-1:0]                   r_rr_ptr [BANKS];
  logic [BANKS-1:0]                 r_bank_en;
  logic [BANKS-1:0]                 r_bank_we;
  logic [BANKS*BANK_ADDR_WIDTH-1:0] r_bank_addr;
  logic [BANKS*DATA_WIDTH-1:0]      r_bank_wdata;
  logic [BANKS-1:0]                 r_s1_rd;
  logic [IDW-1:0]                   r_s1_id [BANKS];
  logic [BANKS-1:0]                 r_s2_rd;
  logic [IDW-1:0]                   r_s2_id [BANKS];

  always_comb begin
    for (int r = 0; r < REQS; r++) begin
      w_req_bank[r]  = req_addr[r*ADDR_WIDTH+3 +: BB];
      w_req_baddr[r] = '0;
      w_req_baddr[r][3 +: WORD_W] = req_addr[r*ADDR_WIDTH+3+BB +: WORD_W];
      w_unused[r*3 +: 3] = req_addr[r*ADDR_WIDTH +: 3];
    end
  end

  // Each port decodes to exactly one bank, so it can win at most one bank per cycle.
  always_comb begin
    w_ready = '0;
    for (int b = 0; b < BANKS; b++) begin
      w_found[b] = 1'b0;
      w_win[b]   = '0;
      for (int r = 0; r < REQS; r++)
        w_cand[b][r] = req_valid[r] && (w_req_bank[r] == BB'(b));
      for (int k = 0; k < REQS; k++) begin
        if (!w_found[b] && w_cand[b][(int'(r_rr_ptr[b]) + k) % REQS]) begin
          w_found[b] = 1'b1;
          w_win[b]   = IDW'((int'(r_rr_ptr[b]) + k) % REQS);
        end
      end
      w_gnt[b] = w_found[b] && bank_ready[b];
      if (w_gnt[b]) w_ready[w_win[b]] = 1'b1;
    end
  end

  assign req_ready = rst ? '0 : w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_en    <= '0;
      r_bank_we    <= '0;
      r_bank_addr  <= '0;
      r_bank_wdata <= '0;
      r_s1_rd      <= '0;
      r_s2_rd      <= '0;
      for (int b = 0; b < BANKS; b++) begin
        r_rr_ptr[b] <= '0;
        r_s1_id[b]  <= '0;
        r_s2_id[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        r_bank_en[b] <= w_gnt[b];
        r_bank_we[b] <= w_gnt[b] && req_we[w_win[b]];
        r_s1_rd[b]   <= w_gnt[b] && !req_we[w_win[b]];
        r_s1_id[b]   <= w_win[b];
        r_s2_rd[b]   <= r_s1_rd[b];
        r_s2_id[b]   <= r_s1_id[b];
        if (w_gnt[b]) begin
          r_bank_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] <= w_req_baddr[w_win[b]];
          r_bank_wdata[b*DATA_WIDTH +: DATA_WIDTH] <= req_wdata[w_win[b]*DATA_WIDTH +: DATA_WIDTH];
          r_rr_ptr[b] <= (w_win[b] == IDW'(REQS-1)) ? '0 : w_win[b] + 1'b1;
        end
      end
    end
  end

  assign bank_enable   = r_bank_en;
  assign bank_write_en = r_bank_we;
  assign bank_addr     = r_bank_addr;
  assign bank_wdata    = r_bank_wdata;

  // Stage 2 lines up with the SRAM read data, one cycle after the bank saw enable.
  always_comb begin
    w_resp_vld = '0;
    resp_rdata = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (!rst && r_s2_rd[b]) begin
        w_resp_vld[r_s2_id[b]] = 1'b1;
        resp_rdata[r_s2_id[b]*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign resp_valid = w_resp_vld;

`ifdef TILE_ARB_PERF_EN
  logic [15:0]      r_perf [BANKS];
  logic [BANKS-1:0] w_conflict;

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      w_conflict[b] = ($countones(w_cand[b]) >= 2) || ((|w_cand[b]) && !bank_ready[b]);
      perf_conflict_cnt[b*16 +: 16] = r_perf[b];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (rst)
        r_perf[b] <= '0;
      else if (w_conflict[b] && r_perf[b] != 16'hFFFF)
        r_perf[b] <= r_perf[b] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Directed bench for tile_mem_arbiter with a behavioural 4-bank SRAM attached.
// Define TILE_ARB_PERF_EN to also exercise the conflict counters.
module tb_tile_mem_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_we, resp_valid;
  logic [59:0]  req_addr;
  logic [255:0] req_wdata, resp_rdata;
  logic [3:0]   bank_enable, bank_write_en, bank_ready;
  logic [51:0]  bank_addr;
  logic [255:0] bank_wdata, bank_rdata;
`ifdef TILE_ARB_PERF_EN
  logic [63:0]  perf_conflict_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] mem [4][1024];
  localparam logic [63:0] WR_DATA  = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] WR_DATA2 = 64'h01234567_89ABCDEF;

  tile_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bank_enable(bank_enable), .bank_write_en(bank_write_en),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata), .bank_ready(bank_ready)
`ifdef TILE_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(int b, int w);
    return {32'hC0DE_0000 | 32'(b), 32'(w) ^ 32'h5A5A_0000};
  endfunction

  // Behavioural SRAM: registered read, data valid the cycle after enable.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_enable[b]) begin
        if (bank_write_en[b]) mem[b][bank_addr[b*13+3 +: 10]] <= bank_wdata[b*64 +: 64];
        else bank_rdata[b*64 +: 64] <= mem[b][bank_addr[b*13+3 +: 10]];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(int r, logic we, logic [14:0] addr, logic [63:0] wd);
    req_we[r] = we;
    req_addr[r*15 +: 15] = addr;
    req_wdata[r*64 +: 64] = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bank_ready = 4'hF;
    req_valid = 4'hF;
    for (int r = 0; r < 4; r++) set_req(r, 1'b0, 15'(r*8), 64'h0);
    cyc(); cyc(); settle();
    n_chk++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", req_ready); else n_pass++;
    n_chk++; if (resp_valid !== 4'b0000) $display("FAIL rst_resp: got %b want 0000", resp_valid); else n_pass++;
    n_chk++; if (bank_enable !== 4'b0000) $display("FAIL rst_en: got %b want 0000", bank_enable); else n_pass++;
    n_chk++; if (bank_addr !== 52'h0 || bank_wdata !== 256'h0) $display("FAIL rst_bus: addr %h wdata %h want 0", bank_addr, bank_wdata); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (dut.r_rr_ptr[b] !== 2'd0) $display("FAIL rst_ptr%0d: got %0d want 0", b, dut.r_rr_ptr[b]); else n_pass++;
    end
    cyc();
    rst = 1'b0;
    req_valid = 4'h0;
  endtask

  task automatic test_write_read();
    cyc();
    req_valid = 4'b0001; set_req(0, 1'b1, 15'h0008, WR_DATA); settle();
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL wr_ready: got %b want 0001", req_ready); else n_pass++;
    cyc();
    req_valid = 4'b0000; settle();
    n_chk++; if (bank_enable !== 4'b0010 || bank_write_en !== 4'b0010) $display("FAIL wr_issue: en %b we %b want 0010 0010", bank_enable, bank_write_en); else n_pass++;
    n_chk++; if (bank_addr[13 +: 13] !== 13'h0 || bank_wdata[64 +: 64] !== WR_DATA) $display("FAIL wr_bus: addr %h wdata %h want 0 %h", bank_addr[13 +: 13], bank_wdata[64 +: 64], WR_DATA); else n_pass++;
    cyc();
    req_valid = 4'b0001; set_req(0, 1'b0, 15'h0008, 64'h0); settle();
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL rd_ready: got %b want 0001", req_ready); else n_pass++;
    cyc();
    req_valid = 4'b0000; settle();
    n_chk++; if (bank_enable !== 4'b0010 || bank_write_en !== 4'b0000 || bank_addr[13 +: 13] !== 13'h0) $display("FAIL rd_issue: en %b we %b addr %h want 0010 0000 0", bank_enable, bank_write_en, bank_addr[13 +: 13]); else n_pass++;
    n_chk++; if (resp_valid !== 4'b0000) $display("FAIL rd_early: got %b want 0000", resp_valid); else n_pass++;
    cyc(); settle();
    n_chk++; if (resp_valid !== 4'b0001) $display("FAIL rd_resp: got %b want 0001", resp_valid); else n_pass++;
    n_chk++; if (resp_rdata[63:0] !== WR_DATA || resp_rdata[255:64] !== 192'h0) $display("FAIL rd_data: got %h want %h", resp_rdata, WR_DATA); else n_pass++;
    n_chk++; if (dut.r_rr_ptr[1] !== 2'd1) $display("FAIL rd_ptr: got %0d want 1", dut.r_rr_ptr[1]); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy, exp_rsp;
    int         rp;
    for (int r = 0; r < 4; r++) set_req(r, 1'b0, 15'(r*32 + 16), 64'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      req_valid = (i < 8) ? 4'hF : 4'h0;
      settle();
      exp_rdy = (i < 8) ? 4'(1 << (i % 4)) : 4'h0;
      rp      = (i - 2) % 4;
      exp_rsp = (i >= 2) ? 4'(1 << rp) : 4'h0;
      n_chk++; if (req_ready !== exp_rdy) $display("FAIL rr_ready c%0d: got %b want %b", i, req_ready, exp_rdy); else n_pass++;
      n_chk++; if (resp_valid !== exp_rsp) $display("FAIL rr_resp c%0d: got %b want %b", i, resp_valid, exp_rsp); else n_pass++;
      if (i >= 2) begin
        n_chk++; if (resp_rdata[rp*64 +: 64] !== pat(2, rp)) $display("FAIL rr_data c%0d: got %h want %h", i, resp_rdata[rp*64 +: 64], pat(2, rp)); else n_pass++;
      end
    end
  endtask

  task automatic test_all_banks();
    logic [63:0] exp_d;
    cyc();
    for (int r = 0; r < 4; r++) set_req(r, 1'b0, 15'(r*8), 64'h0);
    req_valid = 4'hF; settle();
    n_chk++; if (req_ready !== 4'hF) $display("FAIL par_ready: got %b want 1111", req_ready); else n_pass++;
    cyc();
    req_valid = 4'h0; settle();
    n_chk++; if (bank_enable !== 4'hF || bank_write_en !== 4'h0 || bank_addr !== 52'h0) $display("FAIL par_issue: en %b we %b addr %h want 1111 0000 0", bank_enable, bank_write_en, bank_addr); else n_pass++;
    cyc(); settle();
    n_chk++; if (resp_valid !== 4'hF) $display("FAIL par_resp: got %b want 1111", resp_valid); else n_pass++;
    for (int r = 0; r < 4; r++) begin
      exp_d = (r == 1) ? WR_DATA : pat(r, 0);
      n_chk++; if (resp_rdata[r*64 +: 64] !== exp_d) $display("FAIL par_data%0d: got %h want %h", r, resp_rdata[r*64 +: 64], exp_d); else n_pass++;
    end
  endtask

  task automatic test_bank_not_ready();
    cyc();
    bank_ready = 4'b0111;
    req_valid = 4'b0010; set_req(1, 1'b0, 15'h0018, 64'h0);
    for (int i = 0; i < 5; i++) begin
      settle();
      n_chk++; if (req_ready !== 4'b0000 || bank_enable !== 4'b0000) $display("FAIL nr_wait c%0d: ready %b en %b want 0000 0000", i, req_ready, bank_enable); else n_pass++;
      n_chk++; if (dut.r_rr_ptr[3] !== 2'd0) $display("FAIL nr_ptr c%0d: got %0d want 0", i, dut.r_rr_ptr[3]); else n_pass++;
      cyc();
    end
    bank_ready = 4'hF; settle();
    n_chk++; if (req_ready !== 4'b0010) $display("FAIL nr_grant: got %b want 0010", req_ready); else n_pass++;
    cyc();
    req_valid = 4'h0; settle();
    n_chk++; if (bank_enable !== 4'b1000 || dut.r_rr_ptr[3] !== 2'd2) $display("FAIL nr_issue: en %b ptr %0d want 1000 2", bank_enable, dut.r_rr_ptr[3]); else n_pass++;
    cyc(); settle();
    n_chk++; if (resp_valid !== 4'b0010 || resp_rdata[64 +: 64] !== pat(3, 0)) $display("FAIL nr_resp: vld %b data %h want 0010 %h", resp_valid, resp_rdata[64 +: 64], pat(3, 0)); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    cyc();
    req_valid = 4'b0001; set_req(0, 1'b0, 15'h0000, 64'h0); settle();
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL mr_ready: got %b want 0001", req_ready); else n_pass++;
    cyc();
    req_valid = 4'h0; rst = 1'b1; settle();
    n_chk++; if (bank_enable !== 4'b0001 || resp_valid !== 4'b0000) $display("FAIL mr_issue: en %b resp %b want 0001 0000", bank_enable, resp_valid); else n_pass++;
    cyc();
    rst = 1'b0; settle();
    n_chk++; if (resp_valid !== 4'b0000 || bank_enable !== 4'b0000) $display("FAIL mr_after: resp %b en %b want 0000 0000", resp_valid, bank_enable); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (dut.r_rr_ptr[b] !== 2'd0) $display("FAIL mr_ptr%0d: got %0d want 0", b, dut.r_rr_ptr[b]); else n_pass++;
    end
    cyc(); settle();
    n_chk++; if (resp_valid !== 4'b0000) $display("FAIL mr_late: got %b want 0000", resp_valid); else n_pass++;
  endtask

  task automatic test_read_write_same_addr();
    cyc();
    set_req(1, 1'b0, 15'h0020, 64'h0);
    set_req(2, 1'b1, 15'h0020, WR_DATA2);
    req_valid = 4'b0110; settle();
    n_chk++; if (req_ready !== 4'b0010) $display("FAIL rw_first: got %b want 0010", req_ready); else n_pass++;
    cyc();
    req_valid = 4'b0100; settle();
    n_chk++; if (req_ready !== 4'b0100) $display("FAIL rw_second: got %b want 0100", req_ready); else n_pass++;
    n_chk++; if (bank_enable !== 4'b0001 || bank_write_en !== 4'b0000) $display("FAIL rw_issue_rd: en %b we %b want 0001 0000", bank_enable, bank_write_en); else n_pass++;
    cyc();
    req_valid = 4'h0; settle();
    n_chk++; if (bank_enable !== 4'b0001 || bank_write_en !== 4'b0001 || bank_wdata[63:0] !== WR_DATA2) $display("FAIL rw_issue_wr: en %b we %b wdata %h", bank_enable, bank_write_en, bank_wdata[63:0]); else n_pass++;
    n_chk++; if (resp_valid !== 4'b0010 || resp_rdata[64 +: 64] !== pat(0, 1)) $display("FAIL rw_old: vld %b data %h want 0010 %h", resp_valid, resp_rdata[64 +: 64], pat(0, 1)); else n_pass++;
    cyc();
    req_valid = 4'b0001; set_req(0, 1'b0, 15'h0020, 64'h0); settle();
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL rw_rd2_ready: got %b want 0001", req_ready); else n_pass++;
    cyc();
    req_valid = 4'h0;
    cyc(); settle();
    n_chk++; if (resp_valid !== 4'b0001 || resp_rdata[63:0] !== WR_DATA2) $display("FAIL rw_new: vld %b data %h want 0001 %h", resp_valid, resp_rdata[63:0], WR_DATA2); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rsp;
    for (int i = 0; i < 5; i++) begin
      cyc();
      req_valid = (i < 3) ? 4'b1000 : 4'b0000;
      if (i < 3) set_req(3, 1'b0, 15'((5 + i)*32 + 16), 64'h0);
      settle();
      exp_rsp = (i >= 2) ? 4'b1000 : 4'b0000;
      n_chk++; if (req_ready !== req_valid) $display("FAIL b2b_ready c%0d: got %b want %b", i, req_ready, req_valid); else n_pass++;
      n_chk++; if (resp_valid !== exp_rsp) $display("FAIL b2b_resp c%0d: got %b want %b", i, resp_valid, exp_rsp); else n_pass++;
      if (i >= 2) begin
        n_chk++; if (resp_rdata[192 +: 64] !== pat(2, 3 + i)) $display("FAIL b2b_data c%0d: got %h want %h", i, resp_rdata[192 +: 64], pat(2, 3 + i)); else n_pass++;
      end
    end
  endtask

`ifdef TILE_ARB_PERF_EN
  task automatic test_perf();
    cyc();
    rst = 1'b1; req_valid = 4'h0;
    cyc();
    rst = 1'b0;
    set_req(0, 1'b0, 15'h0000, 64'h0);
    set_req(1, 1'b0, 15'h0020, 64'h0);
    req_valid = 4'b0011;
    repeat (10) cyc();
    req_valid = 4'h0; settle();
    n_chk++; if (perf_conflict_cnt[15:0] !== 16'd10) $display("FAIL perf_cnt: got %0d want 10", perf_conflict_cnt[15:0]); else n_pass++;
    n_chk++; if (perf_conflict_cnt[63:16] !== 48'h0) $display("FAIL perf_other: got %h want 0", perf_conflict_cnt[63:16]); else n_pass++;
    bank_ready = 4'b1110; req_valid = 4'b0001;
    repeat (65540) cyc();
    req_valid = 4'h0; bank_ready = 4'hF; settle();
    n_chk++; if (perf_conflict_cnt[15:0] !== 16'hFFFF) $display("FAIL perf_sat: got %h want ffff", perf_conflict_cnt[15:0]); else n_pass++;
  endtask
`endif

  initial begin
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 1024; w++) mem[b][w] = pat(b, w);
    bank_rdata = '0;
    req_we = '0; req_addr = '0; req_wdata = '0; req_valid = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_all_banks();
    test_bank_not_ready();
    test_reset_midflight();
    test_read_write_same_addr();
    test_back_to_back();
`ifdef TILE_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Request arbiter and bank router placed directly upstream of the tile 32KB SRAM (4 banks × 8KB, 64-bit, 1-cycle registered read).
- Accepts independent memory requests from REQS PE-array ports and word-interleaves them across banks.
- Arbitrates per-bank conflicts round-robin and drives the flattened bank_enable/bank_write_en/bank_addr/bank_wdata bus from registers.
- Routes returning bank_rdata back to the originating port with fixed latency.

Parameters:
- REQS, 4, number of requester ports.
- BANKS, 4, number of SRAM banks; power of two.
- ADDR_WIDTH, 15, requester byte address width (32KB tile space).
- BANK_ADDR_WIDTH, 13, per-bank byte address width driven to memory.
- DATA_WIDTH, 64, data path width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  REQS  per-port request valid.
- req_ready  out  REQS  per-port grant; handshake = valid & ready.
- req_we  in  REQS  1 = write, 0 = read.
- req_addr  in  REQS*ADDR_WIDTH  byte address; bits [2:0] ignored.
- req_wdata  in  REQS*DATA_WIDTH  write data.
- resp_valid  out  REQS  read data valid.
- resp_rdata  out  REQS*DATA_WIDTH  read data.
- bank_enable  out  BANKS  to memory.
- bank_write_en  out  BANKS  to memory.
- bank_addr  out  BANKS*BANK_ADDR_WIDTH  to memory; bits [2:0] driven 0.
- bank_wdata  out  BANKS*DATA_WIDTH  to memory.
- bank_rdata  in  BANKS*DATA_WIDTH  from memory; valid the cycle after enable.
- bank_ready  in  BANKS  bank may accept access this cycle.

Behaviour:
- Decode:
  - bank = addr[4:3] (log2 BANKS bits above the word offset).
  - bank_addr = {addr[14:5], 3'b000}, i.e. 1024 words per bank.
- Arbitration (combinational, per bank):
  - Candidates are the ports with req_valid set and a decoded bank equal to b.
  - A bank grants only when bank_ready[b] = 1.
  - Winner is the first candidate at or after rr_ptr[b], searching upward with wrap.
  - req_ready[r] = 1 only for winners.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
  - A port wins at most one bank per cycle.
- rr_ptr[b]:
  - On a grant, advances to (winner+1) mod REQS; otherwise holds.
  - Reset value 0.
  - Worst-case wait for a continuously requesting port: REQS-1 cycles.
- Issue stage (registered):
  - On the edge ending grant cycle T, bank_* outputs load the winner's enable=1, we, addr and wdata.
  - They are presented to memory during T+1.
  - With no grant, bank_enable[b] = 0; addr/wdata hold.
- Tracking (two stages per bank):
  - Stage 1 loads {rd_pend, id} with the issue; rd_pend = grant & ~we.
  - Stage 2 copies stage 1 on the next edge.
- Response:
  - In cycle T+2, resp_valid[id] = 1 and resp_rdata[id] = bank_rdata[b], with b taken from the stage-2 entry.
  - Read latency from handshake is exactly 2 cycles.
  - Writes produce no response.
  - Responses never collide on a port: one grant per port per cycle plus fixed latency keeps them in order.
  - Unselected resp_rdata lanes are 0.
- Reset (rst=1 at an edge):
  - bank_enable, bank_write_en, bank_addr, bank_wdata, all tracking valids and rr_ptr clear to 0.
  - resp_valid and req_ready are 0 while rst is high.
  - Reset mid-operation discards in-flight reads: no resp_valid is produced for them after reset.
- Boundaries:
  - bank_ready[b]=0: no grant to b; requests wait; pointer holds.
  - Back-to-back same-bank reads by one port complete one per cycle.
  - All REQS ports to distinct banks: all granted in the same cycle.
  - Read and write to the same address in the same cycle from different ports: the lower-priority one waits. Order follows grant order; the SRAM's read-during-write behaviour is not relied upon across cycles.

Optional Feature:
- Macro: TILE_ARB_PERF_EN.
- Defined:
  - Adds output perf_conflict_cnt, BANKS*16 bits.
  - Per-bank saturating counter increments by 1 each cycle in which that bank has ≥2 candidates, or ≥1 candidate while bank_ready=0.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Port0 reads addr 0x0008 (bank1, word0) after a prior write of 0xDEADBEEF_CAFEF00D at the same address → bank_enable=4'b0010 in T+1 with bank_addr=0, resp_valid[0]=1 in T+2 with matching data.
- Ports 0–3 all continuously read addresses in bank2 for 8 cycles → grants in order 0,1,2,3,0,1,2,3; each resp_valid exactly 2 cycles after its grant.
- Ports 0–3 target banks 0,1,2,3 simultaneously → all req_ready=1 in one cycle; bank_enable=4'b1111 next cycle.
- Hold bank_ready[3]=0 for 5 cycles while port1 requests addr 0x0018 → req_ready[1]=0 for 5 cycles, grant in cycle 6, rr_ptr[3] unchanged until then.
- Read granted at T, rst asserted at T+1 → no resp_valid at T+2; bank_enable=0 and rr_ptr=0 after reset.
- With TILE_ARB_PERF_EN, two ports hit bank0 for 10 cycles → perf_conflict_cnt[15:0]=10; forced to 65540 conflicts → saturates at 0xFFFF.
